// File: rtl/adder_arb_pkg.sv
// Shared constants and types for the time-multiplexed adder arbiter.
package adder_arb_pkg;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned DATA_W  = 16;
    localparam int unsigned ID_W    = 2;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

    typedef logic [ID_W-1:0] req_id_t;

endpackage

// File: rtl/adder_share_arbiter_if.sv
// Request/response bus between requesters and the shared adder.
// ADDER_ARB_SUB_EN adds the per-requester subtract select req_sub.
interface adder_share_arbiter_if
    import adder_arb_pkg::*;
();
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_a;
    logic [NUM_REQ*DATA_W-1:0] req_b;
    logic [NUM_REQ-1:0]        req_cin;
`ifdef ADDER_ARB_SUB_EN
    logic [NUM_REQ-1:0]        req_sub;
`endif
    logic [NUM_REQ-1:0]        req_ready;
    logic                      rsp_valid;
    logic                      rsp_ready;
    req_id_t                   rsp_id;
    logic [DATA_W-1:0]         rsp_sum;
    logic                      rsp_cout;
    logic                      busy;

    modport slave (
        input  req_valid, req_a, req_b, req_cin,
`ifdef ADDER_ARB_SUB_EN
        input  req_sub,
`endif
        input  rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, busy
    );

    modport master (
        output req_valid, req_a, req_b, req_cin,
`ifdef ADDER_ARB_SUB_EN
        output req_sub,
`endif
        output rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, busy
    );
endinterface

// File: rtl/prefix_adder_16.sv
// 16-bit Kogge-Stone prefix adder with carry-in.
module prefix_adder_16
    import adder_arb_pkg::*;
(
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic              cin_i,
    output logic [DATA_W-1:0] sum_o,
    output logic              cout_o
);
    logic [DATA_W-1:0] p0, g, p, gn, pn;
    logic [DATA_W:0]   c;

    always_comb begin
        p0 = a_i ^ b_i;
        g  = a_i & b_i;
        p  = p0;
        gn = '0;
        pn = '0;
        for (int k = 0; k < 4; k++) begin
            gn = g;
            pn = p;
            for (int i = (1 << k); i < DATA_W; i++) begin
                gn[i] = g[i] | (p[i] & g[i - (1 << k)]);
                pn[i] = p[i] & p[i - (1 << k)];
            end
            g = gn;
            p = pn;
        end
        // Group terms span [i:0]; fold in the carry-in to get every carry.
        c      = {g | (p & {DATA_W{cin_i}}), cin_i};
        sum_o  = p0 ^ c[DATA_W-1:0];
        cout_o = c[DATA_W];
    end
endmodule

// File: rtl/rr_arbiter_4.sv
// Round-robin grant: first valid requester at or after ptr, wrapping 3->0.
module rr_arbiter_4
    import adder_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req_i,
    input  req_id_t            ptr_i,
    output req_id_t            gnt_o,
    output logic               any_o
);
    req_id_t idx;

    // Scan from the farthest offset down so the nearest valid requester wins.
    always_comb begin
        gnt_o = '0;
        any_o = 1'b0;
        idx   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = ptr_i + ID_W'(k);
            if (req_i[idx]) begin
                gnt_o = idx;
                any_o = 1'b1;
            end
        end
    end
endmodule

// File: rtl/adder_share_arbiter.sv
// One shared prefix adder time-multiplexed across four requesters with a
// single-entry result register. ADDER_ARB_SUB_EN enables per-requester A-B.
module adder_share_arbiter
    import adder_arb_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    adder_share_arbiter_if.slave  bus
);
    req_id_t           gnt, ptr_q, ptr_d, id_q;
    logic              any_vld, slot_free, accept;
    state_e            state_q;
    logic [DATA_W-1:0] a_sel, b_sel, add_sum, sum_q;
    logic              cin_sel, add_cout, cout_q;

    rr_arbiter_4 u_arb (
        .req_i (bus.req_valid),
        .ptr_i (ptr_q),
        .gnt_o (gnt),
        .any_o (any_vld)
    );

    // Operand mux driven by the current winner.
    always_comb begin
        a_sel   = bus.req_a[DATA_W*gnt +: DATA_W];
        b_sel   = bus.req_b[DATA_W*gnt +: DATA_W];
        cin_sel = bus.req_cin[gnt];
`ifdef ADDER_ARB_SUB_EN
        if (bus.req_sub[gnt]) begin
            b_sel   = ~b_sel;
            cin_sel = 1'b1;
        end
`endif
    end

    prefix_adder_16 u_add (
        .a_i    (a_sel),
        .b_i    (b_sel),
        .cin_i  (cin_sel),
        .sum_o  (add_sum),
        .cout_o (add_cout)
    );

    assign slot_free     = (state_q == ST_EMPTY) | bus.rsp_ready;
    assign accept        = ~rst & any_vld & slot_free;
    assign ptr_d         = accept ? gnt + ID_W'(1) : ptr_q;
    assign bus.req_ready = accept ? (NUM_REQ'(1) << gnt) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            id_q    <= '0;
            ptr_q   <= '0;
        end else begin
            case (state_q)
                ST_EMPTY: if (accept) state_q <= ST_FULL;
                ST_FULL:  if (!accept && bus.rsp_ready) state_q <= ST_EMPTY;
                default:  state_q <= ST_EMPTY;
            endcase
            if (accept) begin
                sum_q  <= add_sum;
                cout_q <= add_cout;
                id_q   <= gnt;
            end
            ptr_q <= ptr_d;
        end
    end

    // Outputs read as idle while reset is held so a dropped result never shows.
    assign bus.rsp_valid = ~rst & (state_q == ST_FULL);
    assign bus.rsp_sum   = rst ? '0 : sum_q;
    assign bus.rsp_cout  = ~rst & cout_q;
    assign bus.rsp_id    = rst ? '0 : id_q;
    assign bus.busy      = bus.rsp_valid | (|bus.req_valid);
endmodule

// File: doc/adder_share_arbiter.md
ADDER_SHARE_ARBITER -- requirements
Module: adder_share_arbiter

Interface
REQ-001 No parameters; all widths and counts SHALL come from package constants (NUM_REQ=4, DATA_W=16, ID_W=2).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 req_valid  input  4  per-requester operation request.
REQ-005 req_a  input  64  operand A, requester i on bits [16i+15:16i].
REQ-006 req_b  input  64  operand B, same packing as req_a.
REQ-007 req_cin  input  4  per-requester carry-in.
REQ-008 req_ready  output  4  accept strobe, at most one bit set per cycle.
REQ-009 rsp_valid  output  1  result register holds a valid result.
REQ-010 rsp_ready  input  1  downstream consumes the result this cycle.
REQ-011 rsp_id  output  2  index of the requester that owns the result.
REQ-012 rsp_sum  output  16  registered 16-bit sum.
REQ-013 rsp_cout  output  1  registered carry-out.
REQ-014 busy  output  1  high when rsp_valid is set or any req_valid bit is set.

Function
REQ-015 One shared 16-bit prefix adder SHALL be time-multiplexed across 4 requesters; operands SHALL be muxed by the current grant.
REQ-016 Grant SHALL be round-robin: search starts at ptr and wraps 3->0; the first requester with req_valid set wins.
REQ-017 slot_free SHALL equal (!rsp_valid | rsp_ready); req_ready[g] SHALL equal slot_free for the winner g, and all other req_ready bits SHALL be 0.
REQ-018 Accept SHALL mean req_valid[g] & req_ready[g]; on accept, the next edge SHALL load rsp_sum, rsp_cout, rsp_id=g and rsp_valid=1, giving 1-cycle latency.
REQ-019 On accept, ptr SHALL become (g+1) mod 4; with no accept, ptr SHALL hold.
REQ-020 The output FSM SHALL have two states. EMPTY->FULL on accept. FULL->EMPTY on rsp_ready with no accept. FULL->FULL on accept with simultaneous drain, where the new result replaces the old. FULL with no rsp_ready SHALL stall.
REQ-021 While stalled, rsp_sum, rsp_cout and rsp_id SHALL stay stable and req_ready SHALL be 0.
REQ-022 With no valid requesters, all req_ready bits SHALL be 0 and the adder result SHALL be ignored.
REQ-023 Arithmetic SHALL be {cout,sum} = A + B + cin modulo 2^17, with no saturation.
REQ-024 Requesters SHALL hold valid and operands until accepted; the block does not check this.

Reset
REQ-025 While rst=1: rsp_valid=0, rsp_sum=0, rsp_cout=0, rsp_id=0, ptr=0, FSM=EMPTY, req_ready=0.
REQ-026 Reset asserted mid-operation SHALL discard any held result; it is never presented.

Configuration
REQ-027 Macro ADDER_ARB_SUB_EN. When defined, add input req_sub (width 4). For requester g with req_sub[g]=1, the adder SHALL see ~B with carry-in forced to 1, computing A-B; req_cin is ignored for that operation.
REQ-028 When ADDER_ARB_SUB_EN is undefined, the req_sub port and the subtract logic SHALL be absent, and every operation SHALL be A+B+cin.

Structure
REQ-029 Package adder_arb_pkg SHALL hold NUM_REQ, DATA_W, ID_W, the FSM state enum and a req_id_t typedef.
REQ-030 The round-robin grant logic SHALL be one sub-module, rr_arbiter_4, with inputs (req, ptr) and outputs (grant index, any-valid); the shared adder is the existing 16-bit prefix adder, instantiated once.

Verification
REQ-031 Scenario 1: single request; req0 sends A=0x1234, B=0x0FFF, cin=0. Required: req_ready[0]=1 in the same cycle; next cycle rsp_valid=1, rsp_sum=0x2233, rsp_cout=0, rsp_id=0.
REQ-032 Scenario 2: carry out; A=0xFFFF, B=0x0001, cin=1. Required: rsp_sum=0x0001, rsp_cout=1.
REQ-033 Scenario 3: fairness; all 4 requesters held valid and rsp_ready=1 from reset. Required: grant order 0,1,2,3,0, with one result per cycle.
REQ-034 Scenario 4: backpressure; rsp_ready=0 for 3 cycles while req1 is valid. Required: result is held, req_ready=0, ptr is held; when rsp_ready=1 the same cycle accepts req1 and the new result appears the following cycle.
REQ-035 Scenario 5: reset mid-operation; rst=1 in the cycle after an accept. Required: rsp_valid=0 and ptr=0 next cycle; the result is never seen.
REQ-036 Scenario 6 (ADDER_ARB_SUB_EN defined): A=0x0005, B=0x0007, req_sub=1. Required: rsp_sum=0xFFFE, rsp_cout=0.
